// File: rtl/mem_bus_responder_pkg.sv
// ============================================================================
// Module   : mem_resp_pkg
// Purpose  : Shared decode constants and TX drain state type for the
//            byte-serial memory bus responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_resp_pkg;

  localparam logic [1:0] IO_REGION   = 2'b11;
  localparam logic [2:0] IO_OFF_UART = 3'h0;
  localparam logic [2:0] IO_OFF_CTRL = 3'h4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_bus_responder_if.sv
// ============================================================================
// Module   : mem_bus_responder_if
// Purpose  : Byte-serial CPU memory bus between initiator and responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_responder_if;

  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (
    output mem_a,
    output mem_dout,
    output mem_wr,
    input  mem_din,
    input  io_buffer_full
  );

  modport slave (
    input  mem_a,
    input  mem_dout,
    input  mem_wr,
    output mem_din,
    output io_buffer_full
  );

endinterface

`default_nettype wire

// File: rtl/mem_bus_responder_uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Power-of-two byte FIFO feeding the UART TX sink.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  wire logic                     clk_in,
  input  wire logic                     rst_n_in,
  input  wire logic                     push,
  input  wire logic [7:0]               push_data,
  input  wire logic                     pop,
  output logic      [7:0]               head,
  output logic      [$clog2(DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int              c_aw    = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            w_pop;
  logic            w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == c_depth);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_responder.sv
// ============================================================================
// Module   : mem_bus_responder
// Purpose  : RAM + IO responder for the byte-serial memory bus (UART TX FIFO,
//            UART RX source, sim-done flag).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_responder
    import mem_resp_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_FIFO_DEPTH  = 8,
    parameter int TX_GAP_CYCLES  = 4,
    parameter     INIT_FILE      = "test.data"
) (
    input  wire logic             clk_in,
    input  wire logic             rst_n_in,
    mem_bus_responder_if.slave    bus,
    output logic                  uart_tx_valid,
    output logic      [7:0]       uart_tx_data,
    input  wire logic             uart_tx_ready,
    input  wire logic             uart_rx_valid,
    input  wire logic [7:0]       uart_rx_data,
    output logic                  uart_rx_pop,
    output logic                  sim_done
);

    localparam int              c_gap_w = (TX_GAP_CYCLES > 0) ? $clog2(TX_GAP_CYCLES + 1) : 1;
    localparam logic [c_gap_w-1:0] c_gap = c_gap_w'(TX_GAP_CYCLES);
    localparam int              c_unused_init_bits = $bits(INIT_FILE);

    logic [7:0]                r_ram [2**RAM_ADDR_WIDTH];
    logic [7:0]                r_mem_din;
    logic                      r_rx_pop;
    logic                      r_sim_done;
    tx_state_t                 r_state;
    tx_state_t                 w_state_nxt;
    logic [c_gap_w-1:0]        r_gap_cnt;
    logic [c_gap_w-1:0]        w_gap_nxt;
    logic                      w_io_sel;
    logic [2:0]                w_off;
    logic [RAM_ADDR_WIDTH-1:0] w_idx;
    logic                      w_push;
    logic                      w_tx_pop;
    logic                      w_full;
    logic                      w_empty;
    logic [7:0]                w_head;
    logic [$clog2(TX_FIFO_DEPTH):0] w_count;
    logic                      w_unused_bits;

    assign w_io_sel      = (bus.mem_a[17:16] == IO_REGION);
    assign w_off         = bus.mem_a[2:0];
    assign w_idx         = bus.mem_a[RAM_ADDR_WIDTH-1:0];
    assign w_push        = bus.mem_wr & w_io_sel & (w_off == IO_OFF_UART);
    assign w_unused_bits = ^{bus.mem_a[31:18], w_count};

    assign bus.mem_din        = r_mem_din;
    assign bus.io_buffer_full = w_full;
    assign uart_rx_pop        = r_rx_pop;
    assign sim_done           = r_sim_done;
    assign uart_tx_data       = w_head;

    always_ff @(posedge clk_in) begin
        if (bus.mem_wr && !w_io_sel) r_ram[w_idx] <= bus.mem_dout;
    end

    // Read data only updates on read cycles; writes leave the last value on mem_din.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_mem_din  <= 8'h00;
            r_rx_pop   <= 1'b0;
            r_sim_done <= 1'b0;
        end else begin
            r_rx_pop <= ~bus.mem_wr & w_io_sel & (w_off == IO_OFF_UART) & uart_rx_valid;
            if (!bus.mem_wr) begin
                if (w_io_sel)
                    r_mem_din <= ((w_off == IO_OFF_UART) && uart_rx_valid) ? uart_rx_data : 8'h00;
                else
                    r_mem_din <= r_ram[w_idx];
            end
            if (bus.mem_wr && w_io_sel && (w_off == IO_OFF_CTRL)) r_sim_done <= 1'b1;
        end
    end

    uart_tx_fifo #(
        .DEPTH     (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .push      (w_push),
        .push_data (bus.mem_dout),
        .pop       (w_tx_pop),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gap_nxt     = r_gap_cnt;
        w_tx_pop      = 1'b0;
        uart_tx_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) w_state_nxt = SEND;
            end
            SEND: begin
                uart_tx_valid = 1'b1;
                if (uart_tx_ready) begin
                    w_tx_pop = 1'b1;
                    if (TX_GAP_CYCLES == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = GAP;
                        w_gap_nxt   = c_gap;
                    end
                end
            end
            GAP: begin
                // The GAP state is held for exactly TX_GAP_CYCLES cycles.
                w_gap_nxt = r_gap_cnt - 1'b1;
                if (r_gap_cnt <= c_gap_w'(1)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
// ============================================================================
// Module   : tb_mem_bus_responder
// Purpose  : Self-checking bench for mem_bus_responder against a queue/array
//            reference model with directed and random bus traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_responder;

  localparam int DEPTH = 8;
  localparam int GAP_C = 4;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       uart_tx_valid;
  logic [7:0] uart_tx_data;
  logic       uart_tx_ready;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_pop;
  logic       sim_done;

  mem_bus_responder_if bus ();

  mem_bus_responder #(
    .RAM_ADDR_WIDTH (17),
    .TX_FIFO_DEPTH  (DEPTH),
    .TX_GAP_CYCLES  (GAP_C),
    .INIT_FILE      ("test.data")
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .bus            (bus),
    .uart_tx_valid  (uart_tx_valid),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_ready  (uart_tx_ready),
    .uart_rx_valid  (uart_rx_valid),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_pop    (uart_rx_pop),
    .sim_done       (sim_done)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] q [$];
  logic       sim_done_m;
  logic [7:0] din_m;
  logic       din_known;
  int         cyc;
  int         last_pop;
  int         n_cmp;
  int         n_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    sim_done_m = 1'b0;
    din_m      = 8'h00;
    din_known  = 1'b1;
    last_pop   = -1;
  endtask

  // One bus cycle: drive, predict from the pre-edge view, clock, then compare.
  task automatic step(input logic [31:0] a, input logic [7:0] d, input logic wr);
    logic       tx_v;
    logic [7:0] tx_d;
    logic       pop_now;
    logic       full_before;
    logic       io;
    logic [2:0] off;
    logic       rxv;
    logic [7:0] rxd;
    int         idx;
    bus.mem_a    = a;
    bus.mem_dout = d;
    bus.mem_wr   = wr;
    tx_v        = uart_tx_valid;
    tx_d        = uart_tx_data;
    pop_now     = tx_v && uart_tx_ready;
    full_before = (q.size() == DEPTH);
    rxv         = uart_rx_valid;
    rxd         = uart_rx_data;
    io          = (a[17:16] == 2'b11);
    off         = a[2:0];
    idx         = int'(a[16:0]);
    if (pop_now) begin
      check_val("tx_pop_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) check_val("tx_data", 32'(tx_d), 32'(q[0]));
      if (last_pop >= 0) check_val("tx_gap_min", 32'((cyc - last_pop - 1) >= GAP_C), 32'd1);
      last_pop = cyc;
    end
    @(posedge clk_in);
    #1;
    cyc++;
    if (pop_now && q.size() > 0) void'(q.pop_front());
    if (wr) begin
      if (io) begin
        if (off == 3'h0 && (!full_before || pop_now)) q.push_back(d);
        if (off == 3'h4) sim_done_m = 1'b1;
      end else begin
        ram_m[idx] = d;
      end
    end else begin
      if (io) begin
        din_m     = (off == 3'h0 && rxv) ? rxd : 8'h00;
        din_known = 1'b1;
      end else if (ram_m.exists(idx)) begin
        din_m     = ram_m[idx];
        din_known = 1'b1;
      end else begin
        din_known = 1'b0;
      end
    end
    if (din_known) check_val("mem_din", 32'(bus.mem_din), 32'(din_m));
    check_val("rx_pop", 32'(uart_rx_pop), 32'(!wr && io && off == 3'h0 && rxv));
    check_val("io_buffer_full", 32'(bus.io_buffer_full), 32'(q.size() == DEPTH));
    check_val("sim_done", 32'(sim_done), 32'(sim_done_m));
    if (uart_tx_valid) check_val("tx_valid_has_data", 32'(q.size() > 0), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 8'h00, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n;
    uart_tx_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      idle(1);
      n++;
    end
    check_val(tag, 32'(q.size()), 32'd0);
    idle(GAP_C + 2);
    check_val({tag, "_valid_low"}, 32'(uart_tx_valid), 32'd0);
  endtask

  initial begin
    int k;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    model_reset();
    rst_n_in      = 1'b0;
    bus.mem_a     = 32'h0;
    bus.mem_dout  = 8'h00;
    bus.mem_wr    = 1'b0;
    uart_tx_ready = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    repeat (2) @(posedge clk_in);
    #1;
    check_val("rst_mem_din", 32'(bus.mem_din), 32'h0);
    check_val("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
    check_val("rst_rx_pop", 32'(uart_rx_pop), 32'h0);
    check_val("rst_sim_done", 32'(sim_done), 32'h0);
    check_val("rst_full", 32'(bus.io_buffer_full), 32'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // RAM write then read back, reads back-to-back
    step(32'h00100, 8'h11, 1'b1);
    step(32'h00101, 8'h22, 1'b1);
    step(32'h00102, 8'h33, 1'b1);
    step(32'h00103, 8'h44, 1'b1);
    for (int i = 0; i < 4; i++) step(32'h00100 + 32'(i), 8'h00, 1'b0);
    step(32'h00100, 8'h00, 1'b0);
    step(32'h00101, 8'h00, 1'b0);
    check_val("b2b_second", 32'(bus.mem_din), 32'h22);

    // Fill the TX FIFO with the sink stalled, drop a 9th byte, then drain
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) step(32'h30000, 8'h41 + 8'(i), 1'b1);
    check_val("full_after_8", 32'(bus.io_buffer_full), 32'd1);
    step(32'h30000, 8'h49, 1'b1);
    idle(2);
    drain("drain_full");

    // Simultaneous push and pop at count 7
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) step(32'h30000, 8'h61 + 8'(i), 1'b1);
    idle(2);
    uart_tx_ready = 1'b1;
    step(32'h30000, 8'h68, 1'b1);
    uart_tx_ready = 1'b0;
    check_val("cnt7_not_full", 32'(bus.io_buffer_full), 32'd0);
    idle(1);
    drain("drain_cnt7");

    // RX path
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h5A;
    step(32'h30000, 8'h00, 1'b0);
    uart_rx_valid = 1'b0;
    step(32'h30000, 8'h00, 1'b0);
    check_val("rx_empty_din", 32'(bus.mem_din), 32'h00);

    // sim_done sticky
    step(32'h30004, 8'h01, 1'b1);
    idle(3);

    // Random traffic
    for (int i = 0; i < 16; i++) step(32'h00100 + 32'(i), 8'($urandom), 1'b1);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic        wr;
      k             = int'($urandom_range(0, 7));
      wr            = 1'($urandom);
      uart_rx_valid = 1'($urandom);
      uart_rx_data  = 8'($urandom);
      uart_tx_ready = ($urandom_range(0, 3) != 0);
      if (k < 4)       a = 32'h00100 + 32'($urandom_range(0, 15));
      else if (k < 6)  a = 32'h30000;
      else if (k == 6) a = 32'h30004;
      else             a = 32'h30000 + 32'($urandom_range(0, 7));
      if (wr && a[17:16] == 2'b11 && a[2:0] == 3'h0 && q.size() == DEPTH) wr = 1'b0;
      step(a, 8'($urandom), wr);
    end
    uart_rx_valid = 1'b0;
    drain("drain_random");

    // Async reset in the middle of a TX drain with the FIFO full
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) step(32'h30000, 8'h70 + 8'(i), 1'b1);
    uart_tx_ready = 1'b1;
    k = 0;
    while (last_pop < 0 || q.size() == DEPTH) begin
      if (k >= 30) break;
      idle(1);
      k++;
    end
    uart_tx_ready = 1'b0;
    step(32'h30000, 8'h7F, 1'b1);
    k = 0;
    while (!uart_tx_valid && k < 30) begin
      idle(1);
      k++;
    end
    check_val("pre_rst_full", 32'(bus.io_buffer_full), 32'd1);
    check_val("pre_rst_valid", 32'(uart_tx_valid), 32'd1);
    #3;
    rst_n_in = 1'b0;
    #1;
    check_val("async_sim_done", 32'(sim_done), 32'd0);
    check_val("async_tx_valid", 32'(uart_tx_valid), 32'd0);
    check_val("async_full", 32'(bus.io_buffer_full), 32'd0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    model_reset();
    check_val("post_rst_din", 32'(bus.mem_din), 32'h0);
    uart_tx_ready = 1'b1;
    idle(GAP_C + 4);
    check_val("post_rst_tx_valid", 32'(uart_tx_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
